// File: rtl/pwm_cmd_pkg.sv
// Shared constants, FSM state type and reset-default helpers
// for the UART-commanded four-channel PWM controller.
package pwm_cmd_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [3:0] OP_PERIOD = 4'h1;
    localparam logic [3:0] OP_THRESH = 4'h2;
    localparam logic [3:0] OP_ENABLE = 4'h3;
    localparam logic [3:0] OP_READ   = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_D2,
        S_D1,
        S_D0,
        S_CHK,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [63:0] DUTY_PCT [4] = '{64'd10, 64'd20, 64'd30, 64'd40};
    localparam logic [63:0] FREQ_DIV [4] = '{64'd1000, 64'd10000,
                                             64'd100000, 64'd200000};

    function automatic logic [63:0] def_period(logic [63:0] clk_hz, int ch);
        return clk_hz / FREQ_DIV[ch];
    endfunction

    function automatic logic [63:0] def_thresh(logic [63:0] clk_hz, int ch);
        return (def_period(clk_hz, ch) * DUTY_PCT[ch]) / 64'd100;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period and threshold with
// glitch-free transfer at the period boundary.
module pwm_channel
    import pwm_cmd_pkg::*;
#(
    parameter int               CNT_W = 24,
    parameter logic [CNT_W-1:0] P_RST = '0,
    parameter logic [CNT_W-1:0] T_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_period,
    input  logic             wr_thresh,
    input  logic [CNT_W-1:0] wdata,
    input  logic             en,
`ifdef PWM_CMD_READBACK_EN
    output logic [CNT_W-1:0] sh_period,
    output logic [CNT_W-1:0] sh_thresh,
`endif
    output logic             pwm
);

    logic [CNT_W-1:0] sh_p;
    logic [CNT_W-1:0] sh_t;
    logic [CNT_W-1:0] act_p;
    logic [CNT_W-1:0] act_t;
    logic [CNT_W-1:0] cnt;
    logic             p_zero;
    logic             wrap;
    logic             xfer;

    assign p_zero = (act_p == '0);
    assign wrap   = !p_zero && (cnt == act_p - 1'b1);
    // Idle channels follow their shadows so a restart uses fresh values.
    assign xfer   = !en || p_zero || wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_p  <= P_RST;
            sh_t  <= T_RST;
            act_p <= P_RST;
            act_t <= T_RST;
            cnt   <= '0;
            pwm   <= 1'b0;
        end else begin
            if (wr_period) sh_p <= wdata;
            if (wr_thresh) sh_t <= wdata;
            if (xfer) begin
                act_p <= sh_p;
                act_t <= sh_t;
            end
            if (xfer) cnt <= '0;
            else      cnt <= cnt + 1'b1;
            pwm <= en && !p_zero && (cnt < act_t);
        end
    end

`ifdef PWM_CMD_READBACK_EN
    assign sh_period = sh_p;
    assign sh_thresh = sh_t;
`endif

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// UART byte-frame command parser driving four PWM channels.
// Define PWM_CMD_READBACK_EN to add shadow readback (opcode 0x4).
module pwm_cmd_ctrl
    import pwm_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 27_000_000,
    parameter int          CNT_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 270_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [3:0] pwm_out,
    output logic       frame_err
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       cmd_q;
    logic [23:0]      data_q;
    logic [7:0]       chk_q;
    logic [GAP_W-1:0] gap_q;
    logic [3:0]       en_q;
    logic [7:0]       tx_q;
    logic [3:0]       opcode;
    logic [1:0]       ch;
    logic             in_frame;
    logic             timeout;
    logic             sum_ok;
    logic             op_ok;
    logic             good;
    logic             resp_last;
    logic [CNT_W-1:0] wdata;
    logic [3:0]       wr_p;
    logic [3:0]       wr_t;

`ifdef PWM_CMD_READBACK_EN
    logic [1:0]       rb_q;
    logic [23:0]      rb_word_q;
    logic [CNT_W-1:0] sh_p [4];
    logic [CNT_W-1:0] sh_t [4];
    assign resp_last = (rb_q == 2'd0);
`else
    assign resp_last = 1'b1;
`endif

    assign opcode   = cmd_q[7:4];
    assign ch       = cmd_q[1:0];
    assign in_frame = (state_q == S_CMD) || (state_q == S_D2) ||
                      (state_q == S_D1)  || (state_q == S_D0) ||
                      (state_q == S_CHK);
    assign timeout  = in_frame && (gap_q == GAP_W'(TIMEOUT_CYC));
    assign sum_ok   = (cmd_q ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0])
                      == chk_q;
    assign good     = sum_ok && op_ok;
    assign wdata    = CNT_W'(data_q);

    assign tx_valid  = (state_q == S_RESP);
    assign tx_data   = tx_q;
    assign frame_err = ((state_q == S_EXEC) && !good) || timeout;

    always_comb begin
        op_ok = (opcode == OP_PERIOD) || (opcode == OP_THRESH) ||
                (opcode == OP_ENABLE);
`ifdef PWM_CMD_READBACK_EN
        if (opcode == OP_READ) op_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (rx_valid && rx_data == HDR_BYTE) state_d = S_CMD;
            S_CMD:  if (rx_valid) state_d = S_D2;
            S_D2:   if (rx_valid) state_d = S_D1;
            S_D1:   if (rx_valid) state_d = S_D0;
            S_D0:   if (rx_valid) state_d = S_CHK;
            S_CHK:  if (rx_valid) state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (tx_ready && resp_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_comb begin
        wr_p = '0;
        wr_t = '0;
        if (state_q == S_EXEC && good) begin
            if (opcode == OP_PERIOD) wr_p[ch] = 1'b1;
            if (opcode == OP_THRESH) wr_t[ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            data_q    <= '0;
            chk_q     <= '0;
            gap_q     <= '0;
            en_q      <= 4'hF;
            tx_q      <= '0;
`ifdef PWM_CMD_READBACK_EN
            rb_q      <= '0;
            rb_word_q <= '0;
`endif
        end else begin
            if (in_frame && !rx_valid && !timeout) gap_q <= gap_q + 1'b1;
            else                                   gap_q <= '0;
            if (rx_valid) begin
                if (state_q == S_CMD) cmd_q <= rx_data;
                if (state_q == S_D2 || state_q == S_D1 || state_q == S_D0)
                    data_q <= {data_q[15:0], rx_data};
                if (state_q == S_CHK) chk_q <= rx_data;
            end
            if (state_q == S_EXEC) begin
                tx_q <= good ? ACK_BYTE : NAK_BYTE;
                if (good && opcode == OP_ENABLE) en_q <= data_q[3:0];
`ifdef PWM_CMD_READBACK_EN
                rb_q      <= (good && opcode == OP_READ) ? 2'd3 : 2'd0;
                rb_word_q <= cmd_q[2] ? 24'(sh_t[ch]) : 24'(sh_p[ch]);
`endif
            end
`ifdef PWM_CMD_READBACK_EN
            // Readback data follows the ACK, one handshake per byte.
            if (state_q == S_RESP && tx_ready && rb_q != 2'd0) begin
                tx_q      <= rb_word_q[23:16];
                rb_word_q <= {rb_word_q[15:0], 8'h00};
                rb_q      <= rb_q - 2'd1;
            end
`endif
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        localparam logic [63:0] P64 = def_period(64'(CLOCK_FREQ), i);
        localparam logic [63:0] T64 = def_thresh(64'(CLOCK_FREQ), i);
        pwm_channel #(
            .CNT_W (CNT_W),
            .P_RST (P64[CNT_W-1:0]),
            .T_RST (T64[CNT_W-1:0])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_period (wr_p[i]),
            .wr_thresh (wr_t[i]),
            .wdata     (wdata),
            .en        (en_q[i]),
`ifdef PWM_CMD_READBACK_EN
            .sh_period (sh_p[i]),
            .sh_thresh (sh_t[i]),
`endif
            .pwm       (pwm_out[i])
        );
    end

endmodule
